// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and FP constants for the multiplier writeback stage
package fp_pkg;

   localparam int FP_REG_ADDR_W = 5;

   localparam logic [30:0] FP_INF_MAG  = {8'hFF, 23'h0};
   localparam logic [30:0] FP_ZERO_MAG = 31'h0;

   typedef struct packed {
      logic [31:0]              data;
      logic                     ovf;
      logic                     unf;
      logic [FP_REG_ADDR_W-1:0] dest;
   } wb_entry_t;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } fp_wb_state_e;

   // Overflow takes precedence when the multiplier reports both conditions.
   function automatic logic [31:0] fp_substitute(input logic [31:0] raw,
                                                 input logic        ovf,
                                                 input logic        unf);
      logic [31:0] res;
      res = raw;
      if (ovf) begin
         res = {raw[31], FP_INF_MAG};
      end else if (unf) begin
         res = {raw[31], FP_ZERO_MAG};
      end
      return res;
   endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// rtl/fp_wb_fifo.sv - DEPTH-entry FIFO of writeback entries with flush
module fp_wb_fifo
   import fp_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  wb_entry_t     push_data,
   input  logic          pop,
   input  logic          flush,
   output wb_entry_t     head,
   output logic [CW-1:0] count
);

   wb_entry_t     mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Flush wins over everything, including a same-cycle push.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fp_mul_writeback.sv
// rtl/fp_mul_writeback.sv - FP multiplier writeback: buffering, substitution, sticky flags, trap FSM
module fp_mul_writeback
   import fp_pkg::*;
#(
   parameter int  DEPTH      = 2,
   parameter int  REG_ADDR_W = FP_REG_ADDR_W,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_result,
   input  logic                  in_overflow,
   input  logic                  in_underflow,
   input  logic [REG_ADDR_W-1:0] in_dest,
   input  logic                  en_overflow,
   input  logic                  en_underflow,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic [31:0]           wb_data,
   output logic                  flag_overflow,
   output logic                  flag_underflow,
   input  logic                  flags_clear,
   output logic                  trap,
   output logic [1:0]            trap_cause,
   input  logic                  trap_ack,
   input  logic                  flush,
   output logic [CW-1:0]         count
);

   fp_wb_state_e  state_q, state_d;
   logic [1:0]    trap_cause_q, trap_cause_d;
   logic          flag_ovf_q, flag_ovf_d;
   logic          flag_unf_q, flag_unf_d;
   wb_entry_t     push_entry, head;
   logic          push, pop, head_present, head_traps;
   logic [CW-1:0] count_w;

   assign in_ready     = count_w < CW'(DEPTH);
   assign push         = in_valid && in_ready;
   assign head_present = count_w != '0;
   // Enables are evaluated against the head, so they may change while entries wait.
   assign head_traps   = (head.ovf && en_overflow) || (head.unf && en_underflow);

   always_comb begin
      push_entry      = '0;
      push_entry.data = fp_substitute(in_result, in_overflow, in_underflow);
      push_entry.ovf  = in_overflow;
      push_entry.unf  = in_underflow;
      push_entry.dest = in_dest;
   end

   fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (count_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         trap_cause_q <= 2'b00;
         flag_ovf_q   <= 1'b0;
         flag_unf_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         trap_cause_q <= trap_cause_d;
         flag_ovf_q   <= flag_ovf_d;
         flag_unf_q   <= flag_unf_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      trap_cause_d = trap_cause_q;
      case (state_q)
         RUN: begin
            if (head_present && head_traps) begin
               state_d      = TRAP;
               trap_cause_d = {head.unf, head.ovf};
            end
         end
         TRAP: begin
            if (trap_ack) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      wb_valid = 1'b0;
      pop      = 1'b0;
      if (state_q == RUN && head_present) begin
         wb_valid = !head_traps;
         pop      = head_traps || wb_ready;
      end
   end

   // A set from a popping entry overrides a same-cycle clear.
   always_comb begin
      flag_ovf_d = flags_clear ? 1'b0 : flag_ovf_q;
      flag_unf_d = flags_clear ? 1'b0 : flag_unf_q;
      if (pop) begin
         flag_ovf_d = flag_ovf_d || head.ovf;
         flag_unf_d = flag_unf_d || head.unf;
      end
   end

   assign wb_addr        = wb_valid ? REG_ADDR_W'(head.dest) : '0;
   assign wb_data        = wb_valid ? head.data : 32'h0;
   assign trap           = state_q == TRAP;
   assign trap_cause     = trap_cause_q;
   assign flag_overflow  = flag_ovf_q;
   assign flag_underflow = flag_unf_q;
   assign count          = count_w;

endmodule

// File: tb/tb_fp_mul_writeback.sv
// tb/tb_fp_mul_writeback.sv - directed self-checking bench for fp_mul_writeback
module tb_fp_mul_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_result;
   logic        in_overflow, in_underflow;
   logic [4:0]  in_dest;
   logic        en_overflow, en_underflow;
   logic        wb_valid, wb_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flag_overflow, flag_underflow, flags_clear;
   logic        trap, trap_ack, flush;
   logic [1:0]  trap_cause;
   logic [1:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fp_mul_writeback #(.DEPTH(2), .REG_ADDR_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_result      (in_result),
      .in_overflow    (in_overflow),
      .in_underflow   (in_underflow),
      .in_dest        (in_dest),
      .en_overflow    (en_overflow),
      .en_underflow   (en_underflow),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow),
      .flags_clear    (flags_clear),
      .trap           (trap),
      .trap_cause     (trap_cause),
      .trap_ack       (trap_ack),
      .flush          (flush),
      .count          (count)
   );

   task automatic drive_in(input logic v, input logic [31:0] r, input logic o,
                           input logic u, input logic [4:0] d);
      in_valid     = v;
      in_result    = r;
      in_overflow  = o;
      in_underflow = u;
      in_dest      = d;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
      n_checks++; if (wb_data !== 32'h0 || wb_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wb got %h/%0d exp 0/0", wb_data, wb_addr); end
      n_checks++; if (trap !== 1'b0 || trap_cause !== 2'b00) begin n_fail++; $display("FAIL reset_trap got %b/%b exp 0/00", trap, trap_cause); end
      n_checks++; if (flag_overflow !== 1'b0 || flag_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", flag_overflow, flag_underflow); end
      rst_n = 1'b1;
   endtask

   task automatic test_pass_through();
      @(negedge clk);
      wb_ready = 1'b1;
      drive_in(1'b1, 32'h40C00000, 1'b0, 1'b0, 5'd3);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL pt_wb_valid got %b exp 1", wb_valid); end
      n_checks++; if (wb_addr !== 5'd3) begin n_fail++; $display("FAIL pt_wb_addr got %0d exp 3", wb_addr); end
      n_checks++; if (wb_data !== 32'h40C00000) begin n_fail++; $display("FAIL pt_wb_data got %h exp 40c00000", wb_data); end
      @(negedge clk);
      n_checks++; if (wb_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL pt_drain got %b/%0d exp 0/0", wb_valid, count); end
      n_checks++; if (flag_overflow !== 1'b0 || flag_underflow !== 1'b0) begin n_fail++; $display("FAIL pt_flags got %b%b exp 00", flag_overflow, flag_underflow); end
   endtask

   task automatic test_overflow_no_trap();
      @(negedge clk);
      en_overflow = 1'b0;
      wb_ready    = 1'b1;
      drive_in(1'b1, 32'hC0000000, 1'b1, 1'b0, 5'd9);
      @(negedge clk);
      drive_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
      n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hFF800000) begin n_fail++; $display("FAIL ovf_wb got %b/%h exp 1/ff800000", wb_valid, wb_data); end
      n_checks++; if (flag_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_early got %b exp 0", flag_overflow); end
      @(negedge clk);
      n_checks++; if (flag_overflow !== 1'b1 || flag_underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flags got %b%b exp 10", flag_overflow, flag_underflow); end
      n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL ovf_trap got %b exp 0", trap); end
      flags_clear = 1'b1;
      @(negedge clk);
      flags_clear = 1'b0;
      n_checks++; if (flag_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", flag_overflow); end
   endtask

   task automatic test_underflow_trap();
      @(negedge clk);
      en_underflow = 1'b1;
      wb_ready     = 1'b1;
      drive_in(1'b1, 32'h80123456, 1'b0, 1'b1, 5'd2);
      @(negedge clk);
      drive_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
      n_checks++; if (wb_valid !== 1'b0 || trap !== 1'b0 || count !== 2'd1) begin n_fail++; $display("FAIL unf_head got v%b t%b c%0d exp 0 0 1", wb_valid, trap, count); end
      @(negedge clk);
      n_checks++; if (trap !== 1'b1 || trap_cause !== 2'b10) begin n_fail++; $display("FAIL unf_trap got %b/%b exp 1/10", trap, trap_cause); end
      n_checks++; if (flag_underflow !== 1'b1 || flag_overflow !== 1'b0) begin n_fail++; $display("FAIL unf_flags got %b%b exp 01", flag_overflow, flag_underflow); end
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL unf_popped got %0d exp 0", count); end
      en_underflow = 1'b0;
      drive_in(1'b1, 32'h41200000, 1'b0, 1'b0, 5'd7);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (trap !== 1'b1 || count !== 2'd1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL unf_hold got t%b c%0d v%b exp 1 1 0", trap, count, wb_valid); end
      trap_ack = 1'b1;
      @(negedge clk);
      trap_ack = 1'b0;
      n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL unf_ack got %b exp 0", trap); end
      n_checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'h41200000) begin n_fail++; $display("FAIL unf_resume got %b/%0d/%h exp 1/7/41200000", wb_valid, wb_addr, wb_data); end
      @(negedge clk);
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL unf_drain got %0d exp 0", count); end
      flags_clear = 1'b1;
      @(negedge clk);
      flags_clear = 1'b0;
      n_checks++; if (flag_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b exp 0", flag_underflow); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      wb_ready = 1'b0;
      drive_in(1'b1, 32'h3F800000, 1'b0, 1'b0, 5'd1);
      @(negedge clk);
      drive_in(1'b1, 32'h40000000, 1'b0, 1'b0, 5'd2);
      @(negedge clk);
      drive_in(1'b1, 32'h40400000, 1'b0, 1'b0, 5'd4);
      n_checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got c%0d r%b exp 2 0", count, in_ready); end
      n_checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd1 || wb_data !== 32'h3F800000) begin n_fail++; $display("FAIL bp_head got %b/%0d/%h exp 1/1/3f800000", wb_valid, wb_addr, wb_data); end
      @(negedge clk);
      n_checks++; if (count !== 2'd2 || wb_addr !== 5'd1 || wb_data !== 32'h3F800000) begin n_fail++; $display("FAIL bp_stable got c%0d %0d/%h exp 2 1/3f800000", count, wb_addr, wb_data); end
      wb_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (count !== 2'd1 || wb_addr !== 5'd2 || wb_data !== 32'h40000000) begin n_fail++; $display("FAIL bp_no_bypass got c%0d %0d/%h exp 1 2/40000000", count, wb_addr, wb_data); end
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (count !== 2'd1 || wb_addr !== 5'd4 || wb_data !== 32'h40400000) begin n_fail++; $display("FAIL bp_third got c%0d %0d/%h exp 1 4/40400000", count, wb_addr, wb_data); end
      @(negedge clk);
      n_checks++; if (count !== 2'd0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got c%0d v%b exp 0 0", count, wb_valid); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      wb_ready    = 1'b0;
      en_overflow = 1'b0;
      drive_in(1'b1, 32'h3F800000, 1'b1, 1'b0, 5'd5);
      @(negedge clk);
      drive_in(1'b1, 32'h40000000, 1'b0, 1'b1, 5'd6);
      @(negedge clk);
      drive_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL fl_queued got %0d exp 2", count); end
      en_overflow = 1'b1;
      flush       = 1'b1;
      flags_clear = 1'b1;
      @(negedge clk);
      flush       = 1'b0;
      flags_clear = 1'b0;
      n_checks++; if (count !== 2'd0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_empty got c%0d v%b exp 0 0", count, wb_valid); end
      n_checks++; if (flag_overflow !== 1'b1 || flag_underflow !== 1'b0) begin n_fail++; $display("FAIL fl_flags got %b%b exp 10", flag_overflow, flag_underflow); end
      trap_ack = 1'b1;
      @(negedge clk);
      trap_ack    = 1'b0;
      en_overflow = 1'b0;
      n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL fl_ack got %b exp 0", trap); end
      drive_in(1'b1, 32'h3F800000, 1'b0, 1'b0, 5'd1);
      @(negedge clk);
      in_result = 32'h40000000;
      flush     = 1'b1;
      n_checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_drop_pre got c%0d r%b exp 1 1", count, in_ready); end
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      n_checks++; if (count !== 2'd0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drop got c%0d v%b exp 0 0", count, wb_valid); end
      n_checks++; if (flag_overflow !== 1'b1) begin n_fail++; $display("FAIL fl_flags_kept got %b exp 1", flag_overflow); end
   endtask

   task automatic test_reset_midburst();
      @(negedge clk);
      wb_ready = 1'b0;
      drive_in(1'b1, 32'h3F800000, 1'b0, 1'b0, 5'd1);
      @(negedge clk);
      drive_in(1'b1, 32'h40000000, 1'b0, 1'b0, 5'd2);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL rm_queued got %0d exp 2", count); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (count !== 2'd0 || wb_valid !== 1'b0 || trap !== 1'b0) begin n_fail++; $display("FAIL rm_async got c%0d v%b t%b exp 0 0 0", count, wb_valid, trap); end
      n_checks++; if (flag_overflow !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_flags got f%b r%b exp 0 1", flag_overflow, in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n        = 1'b0;
      wb_ready     = 1'b0;
      en_overflow  = 1'b0;
      en_underflow = 1'b0;
      flags_clear  = 1'b0;
      trap_ack     = 1'b0;
      flush        = 1'b0;
      drive_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
      test_reset();
      test_pass_through();
      test_overflow_no_trap();
      test_underflow_trap();
      test_backpressure();
      test_flush();
      test_reset_midburst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
